pin_cmd_ctrl: RTL and testbench

PIN_CMD_CTRL -- requirements
Module: pin_cmd_ctrl

---
 rtl/pin_cmd_ctrl.sv | 159 +++++++++++++++
 tb/tb_pin_cmd_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_cmd_ctrl.sv
// Command-driven controller for a bank of bidirectional pins: a shadow drive image, an apply path and a settle-then-sample path.
// Optional macro PIN_CMD_SYNC_EN adds a 2-stage synchronizer on input_pins_state ahead of the snapshot capture.
module pin_cmd_ctrl #(
    parameter int PINS_CONT     = 132,
    parameter int BYTES         = 17,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  CLK50,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [4:0]            cmd_addr,
    input  logic [7:0]            cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [7:0]            rsp_data,
    output logic                  rsp_err,
    output logic                  write_enable,
    output logic [BYTES-1:0][7:0] output_pins_state,
    input  logic [BYTES-1:0][7:0] input_pins_state
);

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ   = 2'b01,
        OP_APPLY  = 2'b10,
        OP_SAMPLE = 2'b11
    } op_t;

`ifdef PIN_CMD_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 0;
`endif

    // Last SETTLE count value; the capture happens on the cycle the counter reaches it.
    localparam logic [4:0] SETTLE_LAST = 5'(SETTLE_CYCLES + SYNC_STAGES);

    // Lane bits that map to pins beyond PINS_CONT are kept at 0 everywhere.
    localparam logic [BYTES*8-1:0]    PIN_MASK  = {(BYTES*8){1'b1}} >> (BYTES*8 - PINS_CONT);
    localparam logic [BYTES-1:0][7:0] LANE_MASK = PIN_MASK;

    state_t                  state;
    state_t                  next_state;
    logic                    run;
    logic                    accept;
    logic                    capture;
    logic                    addr_ok;
    logic [4:0]              cnt;
    logic [BYTES-1:0][7:0]   shadow;
    logic [BYTES-1:0][7:0]   snapshot;
    logic [BYTES-1:0][7:0]   pin_src;
    op_t                     op;

    assign op        = op_t'(cmd_op);
    assign addr_ok   = (32'(cmd_addr) < BYTES);
    assign cmd_ready = run && (state == IDLE);
    assign rsp_valid = (state == RESP);

`ifdef PIN_CMD_SYNC_EN
    logic [BYTES-1:0][7:0] sync_q1;
    logic [BYTES-1:0][7:0] sync_q2;

    always_ff @(posedge CLK50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= input_pins_state;
            sync_q2 <= sync_q1;
        end
    end

    assign pin_src = sync_q2;
`else
    assign pin_src = input_pins_state;
`endif

    always_ff @(posedge CLK50 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && run) begin
                    accept     = 1'b1;
                    next_state = (op == OP_SAMPLE) ? SETTLE : RESP;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the pin images are plain flop arrays, so they take the async reset like any other register.
    always_ff @(posedge CLK50 or negedge rst_n) begin
        if (!rst_n) begin
            run               <= 1'b0;
            cnt               <= '0;
            shadow            <= '0;
            snapshot          <= '0;
            output_pins_state <= '0;
            write_enable      <= 1'b0;
            rsp_data          <= '0;
            rsp_err           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            run <= 1'b1;
            if (state == SETTLE) cnt <= cnt + 5'd1;

            if (accept) begin
                cnt      <= '0;
                rsp_data <= '0;
                rsp_err  <= 1'b0;
                case (op)
                    OP_WRITE: begin
                        if (addr_ok) begin
                            shadow[cmd_addr] <= cmd_wdata & LANE_MASK[cmd_addr];
                            rsp_data         <= cmd_wdata & LANE_MASK[cmd_addr];
                        end else begin
                            rsp_err <= 1'b1;
                        end
                    end
                    OP_READ: begin
                        if (addr_ok) rsp_data <= snapshot[cmd_addr];
                        else         rsp_err  <= 1'b1;
                    end
                    OP_APPLY: begin
                        output_pins_state <= shadow;
                        write_enable      <= 1'b1;
                    end
                    OP_SAMPLE: begin
                        write_enable <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (capture) snapshot <= pin_src & LANE_MASK;
        end
    end

endmodule

// File: tb/tb_pin_cmd_ctrl.sv
// Self-checking bench for pin_cmd_ctrl: directed vector table, multi-cycle corner sequences and randomized commands vs a lane-array model.
module tb_pin_cmd_ctrl;

    localparam int PINS_CONT     = 132;
    localparam int BYTES         = 17;
    localparam int SETTLE_CYCLES = 4;
`ifdef PIN_CMD_SYNC_EN
    localparam int SAMPLE_LAT = SETTLE_CYCLES + 4;
`else
    localparam int SAMPLE_LAT = SETTLE_CYCLES + 2;
`endif

    localparam logic [1:0] WR = 2'b00, RD = 2'b01, AP = 2'b10, SM = 2'b11;

    logic                  CLK50;
    logic                  rst_n;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [4:0]            cmd_addr;
    logic [7:0]            cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [7:0]            rsp_data;
    logic                  rsp_err;
    logic                  write_enable;
    logic [BYTES-1:0][7:0] output_pins_state;
    logic [BYTES-1:0][7:0] input_pins_state;

    pin_cmd_ctrl #(
        .PINS_CONT     (PINS_CONT),
        .BYTES         (BYTES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .CLK50             (CLK50),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_addr          (cmd_addr),
        .cmd_wdata         (cmd_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .rsp_err           (rsp_err),
        .write_enable      (write_enable),
        .output_pins_state (output_pins_state),
        .input_pins_state  (input_pins_state)
    );

    initial CLK50 = 1'b0;
    always #10 CLK50 = ~CLK50;

    int checks = 0;
    int errors = 0;

    // Reference model: one byte per lane, with pin validity derived bit by bit.
    logic [7:0] shadow_m [BYTES];
    logic [7:0] snap_m   [BYTES];
    logic [7:0] out_m    [BYTES];
    logic       we_m;

    typedef struct {
        logic [1:0] op;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_data;
        logic       exp_err;
        logic       exp_we;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK50);
        #1;
    endtask

    function automatic logic [7:0] lane_mask(input int lane);
        logic [7:0] m;
        for (int b = 0; b < 8; b++) m[b] = ((lane * 8 + b) < PINS_CONT);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BYTES; i++) begin
            shadow_m[i] = '0;
            snap_m[i]   = '0;
            out_m[i]    = '0;
        end
        we_m = 1'b0;
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [7:0] wdata,
                             output logic [7:0] exp_data, output logic exp_err, output int exp_lat);
        int a;
        a        = int'(addr);
        exp_data = '0;
        exp_err  = 1'b0;
        exp_lat  = 1;
        case (op)
            WR: if (a < BYTES) begin
                    shadow_m[a] = wdata & lane_mask(a);
                    exp_data    = shadow_m[a];
                end else exp_err = 1'b1;
            RD: if (a < BYTES) exp_data = snap_m[a];
                else           exp_err  = 1'b1;
            AP: begin
                    for (int i = 0; i < BYTES; i++) out_m[i] = shadow_m[i];
                    we_m = 1'b1;
                end
            default: begin
                    for (int i = 0; i < BYTES; i++) snap_m[i] = input_pins_state[i] & lane_mask(i);
                    we_m    = 1'b0;
                    exp_lat = SAMPLE_LAT;
                end
        endcase
    endtask

    task automatic check_out_pins(input string name);
        int lane;
        lane = 0;
        for (int i = BYTES - 1; i >= 0; i--)
            if (output_pins_state[i] !== out_m[i]) lane = i;
        check($sformatf("%s_lane%0d", name, lane), 32'(output_pins_state[lane]), 32'(out_m[lane]));
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [7:0] wdata, input int hold,
                          output logic [7:0] data, output logic err, output int lat, output logic we_after);
        int n;
        data = '0; err = 1'b0; lat = 0; we_after = 1'b0;
        cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        if (!cmd_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = 5'($urandom);
        cmd_wdata = 8'($urandom);
        we_after  = write_enable;
        lat       = 1;
        while (!rsp_valid && lat < 100) begin tick(); lat++; end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        data = rsp_data;
        err  = rsp_err;
        repeat (hold) tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, "_we"},        32'(write_enable), 32'd0);
        check({tag, "_out_any"},   32'(|output_pins_state), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, ed;
        logic       e, ee, wa;
        int         lat, el, bad;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        for (int i = 0; i < BYTES; i++) input_pins_state[i] = 8'(i * 17 + 1);
        input_pins_state[3]  = 8'h77;
        input_pins_state[5]  = 8'h3C;
        input_pins_state[16] = 8'hFF;
        model_reset();

        // Reset state, then ready on the first edge after release.
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(cmd_ready), 32'd0);
        tick();
        check("ready_after_release", 32'(cmd_ready), 32'd1);

        vecs[0]  = '{WR, 5'd3,  8'hA5, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{AP, 5'd9,  8'h00, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{WR, 5'd16, 8'hFF, 8'h0F, 1'b0, 1'b1};
        vecs[3]  = '{AP, 5'd0,  8'h00, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{RD, 5'd17, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[5]  = '{WR, 5'd31, 8'h5A, 8'h00, 1'b1, 1'b1};
        vecs[6]  = '{SM, 5'd25, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{RD, 5'd5,  8'h00, 8'h3C, 1'b0, 1'b0};
        vecs[8]  = '{RD, 5'd16, 8'h00, 8'h0F, 1'b0, 1'b0};
        vecs[9]  = '{WR, 5'd3,  8'h11, 8'h11, 1'b0, 1'b0};
        vecs[10] = '{RD, 5'd3,  8'h00, 8'h77, 1'b0, 1'b0};
        vecs[11] = '{RD, 5'd0,  8'h00, 8'h01, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            model_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata, ed, ee, el);
            do_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata, 0, d, e, lat, wa);
            check($sformatf("vec%0d_data", i), 32'(d),   32'(vecs[i].exp_data));
            check($sformatf("vec%0d_err", i),  32'(e),   32'(vecs[i].exp_err));
            check($sformatf("vec%0d_we", i),   32'(wa),  32'(vecs[i].exp_we));
            check($sformatf("vec%0d_lat", i),  32'(lat), 32'(el));
        end
        check("apply_lane3",  32'(output_pins_state[3]),  32'h0000_00A5);
        check("apply_lane16", 32'(output_pins_state[16]), 32'h0000_000F);
        check_out_pins("table_out");

        // Back-pressure: response held for 10 cycles while junk commands are presented.
        cmd_op = WR; cmd_addr = 5'd2; cmd_wdata = 8'h5A; cmd_valid = 1'b1;
        tick();
        model_cmd(WR, 5'd2, 8'h5A, ed, ee, el);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            cmd_op = 2'($urandom); cmd_addr = 5'($urandom); cmd_wdata = 8'($urandom);
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A || rsp_err !== 1'b0 || cmd_ready !== 1'b0) bad++;
            tick();
        end
        check("hold_unstable_cycles", 32'(bad), 32'd0);
        check("hold_rsp_data", 32'(rsp_data), 32'h5A);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("ready_after_consume", 32'(cmd_ready), 32'd1);
        check("hold_we", 32'(write_enable), 32'(we_m));
        check_out_pins("hold_out");

        // Reset in the middle of SETTLE discards the SAMPLE.
        model_cmd(AP, 5'd0, 8'h00, ed, ee, el);
        do_cmd(AP, 5'd0, 8'h00, 0, d, e, lat, wa);
        check("pre_rst_we", 32'(write_enable), 32'd1);
        cmd_op = SM; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("sample_we_drop", 32'(write_enable), 32'd0);
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midsettle");
        repeat (2) tick();
        rst_n = 1'b1;
        model_reset();
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (rsp_valid !== 1'b0 || write_enable !== 1'b0) bad++;
        end
        check("post_rst_quiet", 32'(bad), 32'd0);

        // Randomized commands against the model.
        for (int n = 0; n < 200; n++) begin
            logic [1:0] op;
            logic [4:0] addr;
            logic [7:0] wdata;
            op    = 2'($urandom);
            addr  = 5'($urandom_range(0, 16));
            if ($urandom_range(0, 7) == 0) addr = 5'($urandom_range(17, 31));
            wdata = 8'($urandom);
            if (op == SM)
                for (int i = 0; i < BYTES; i++) input_pins_state[i] = 8'($urandom);
            model_cmd(op, addr, wdata, ed, ee, el);
            do_cmd(op, addr, wdata, int'($urandom_range(0, 3)), d, e, lat, wa);
            check($sformatf("rnd%0d_data", n), 32'(d),   32'(ed));
            check($sformatf("rnd%0d_err", n),  32'(e),   32'(ee));
            check($sformatf("rnd%0d_lat", n),  32'(lat), 32'(el));
            check($sformatf("rnd%0d_we", n),   32'(wa),  32'(we_m));
            check_out_pins($sformatf("rnd%0d_out", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
